// File: rtl/seg7_reader.sv
// Seven-segment bus receiver: synchronizes, debounces and classifies a segment pattern into hex/blank/error.
// Optional build macro SEG7_READER_ALT_GLYPH_EN also accepts the alternate 7 (0x27) and 9 (0x67) glyphs.
module seg7_reader #(
    parameter int SYNC_DEPTH    = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [6:0] i_seg,
    output logic [3:0] o_hex,
    output logic       o_valid,
    output logic       o_blank,
    output logic       o_error,
    output logic       o_update
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0]       OFF_LEVEL = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    generate
        if (SYNC_DEPTH < 2) begin : g_bad_sync
            $error("seg7_reader: SYNC_DEPTH must be at least 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("seg7_reader: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    logic [SYNC_DEPTH-1:0][6:0] sync_q;
    logic [6:0]                 s;
    logic [6:0]                 candidate;
    logic [CNT_W-1:0]           counter;
    logic [0:0]                 state;

    logic       cls_valid;
    logic       cls_blank;
    logic       cls_error;
    logic [3:0] cls_hex;
    logic [3:0] next_hex;
    logic       changed;

    // Reset parks the chain at the "all off" level so the bus reads blank, not garbage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_DEPTH{OFF_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], i_seg};
        end
    end

    assign s = sync_q[SYNC_DEPTH-1] ^ {7{ACTIVE_LOW}};

    always_comb begin
        cls_valid = 1'b0;
        cls_blank = 1'b0;
        cls_hex   = 4'h0;
        case (candidate)
            7'h3F: begin cls_valid = 1'b1; cls_hex = 4'h0; end
            7'h06: begin cls_valid = 1'b1; cls_hex = 4'h1; end
            7'h5B: begin cls_valid = 1'b1; cls_hex = 4'h2; end
            7'h4F: begin cls_valid = 1'b1; cls_hex = 4'h3; end
            7'h66: begin cls_valid = 1'b1; cls_hex = 4'h4; end
            7'h6D: begin cls_valid = 1'b1; cls_hex = 4'h5; end
            7'h7D: begin cls_valid = 1'b1; cls_hex = 4'h6; end
            7'h07: begin cls_valid = 1'b1; cls_hex = 4'h7; end
            7'h7F: begin cls_valid = 1'b1; cls_hex = 4'h8; end
            7'h6F: begin cls_valid = 1'b1; cls_hex = 4'h9; end
            7'h77: begin cls_valid = 1'b1; cls_hex = 4'hA; end
            7'h7C: begin cls_valid = 1'b1; cls_hex = 4'hB; end
            7'h39: begin cls_valid = 1'b1; cls_hex = 4'hC; end
            7'h5E: begin cls_valid = 1'b1; cls_hex = 4'hD; end
            7'h79: begin cls_valid = 1'b1; cls_hex = 4'hE; end
            7'h71: begin cls_valid = 1'b1; cls_hex = 4'hF; end
`ifdef SEG7_READER_ALT_GLYPH_EN
            7'h27: begin cls_valid = 1'b1; cls_hex = 4'h7; end
            7'h67: begin cls_valid = 1'b1; cls_hex = 4'h9; end
`endif
            7'h00: cls_blank = 1'b1;
            default: cls_blank = 1'b0;
        endcase
    end

    assign cls_error = !cls_valid && !cls_blank;
    // Blank and error commits keep the last good digit on o_hex.
    assign next_hex  = cls_valid ? cls_hex : o_hex;
    assign changed   = {cls_valid, cls_blank, cls_error, next_hex}
                       != {o_valid, o_blank, o_error, o_hex};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            candidate <= 7'h00;
            counter   <= '0;
            state     <= ST_SETTLE;
            o_hex     <= 4'h0;
            o_valid   <= 1'b0;
            o_blank   <= 1'b0;
            o_error   <= 1'b0;
            o_update  <= 1'b0;
        end else begin
            o_update <= 1'b0;
            // A changed sample always wins, even on the edge that would have committed.
            if (s != candidate) begin
                candidate <= s;
                counter   <= '0;
                state     <= ST_SETTLE;
            end else if (state == ST_SETTLE) begin
                if (counter == CNT_LAST) begin
                    state    <= ST_LOCKED;
                    o_hex    <= next_hex;
                    o_valid  <= cls_valid;
                    o_blank  <= cls_blank;
                    o_error  <= cls_error;
                    o_update <= changed;
                end else begin
                    counter <= counter + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: table-driven glyph sweep, timing corner sequences, and randomized bus traffic.
module tb_seg7_reader;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam bit ALOW   = 1'b1;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [6:0] i_seg;
    logic [3:0] o_hex;
    logic       o_valid, o_blank, o_error, o_update;

    seg7_reader #(.SYNC_DEPTH(SYNC), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(ALOW)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_seg    (i_seg),
        .o_hex    (o_hex),
        .o_valid  (o_valid),
        .o_blank  (o_blank),
        .o_error  (o_error),
        .o_update (o_update)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;

    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: output reflects the latest pattern whose synchronized samples ran STABLE+1 long.
    logic [6:0] in_q [$];
    logic [6:0] s_hist [$];
    bit         m_valid, m_blank, m_error, m_update;
    logic [3:0] m_hex;

    typedef struct {
        logic [6:0] pat;
        bit         valid;
        bit         blank;
        bit         error;
        logic [3:0] hex;
    } vec_t;
    vec_t tab [22];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void ref_classify(input logic [6:0] p, output bit v, output bit b,
                                         output bit e, output int idx);
        idx = -1;
        for (int i = 0; i < 16; i++) if (glyphs[i] == p) idx = i;
`ifdef SEG7_READER_ALT_GLYPH_EN
        if (p == 7'h27) idx = 7;
        if (p == 7'h67) idx = 9;
`endif
        v = (idx >= 0);
        b = !v && (p == 7'h00);
        e = !v && !b;
    endfunction

    task automatic model_reset();
        in_q.delete();
        s_hist.delete();
        s_hist.push_back(7'h00);
        m_valid = 0; m_blank = 0; m_error = 0; m_update = 0; m_hex = 4'h0;
    endtask

    task automatic model_step(input logic [6:0] pat);
        logic [6:0] s;
        int         run;
        bit         v, b, e;
        int         idx;
        logic [3:0] nh;
        in_q.push_back(pat);
        s = (in_q.size() > SYNC) ? in_q[in_q.size() - 1 - SYNC] : 7'h00;
        s_hist.push_back(s);
        run = 0;
        for (int j = s_hist.size() - 1; j >= 0; j--) begin
            if (s_hist[j] != s) break;
            run++;
        end
        m_update = 0;
        if (run == STABLE + 1) begin
            ref_classify(s, v, b, e, idx);
            nh = v ? 4'(idx) : m_hex;
            m_update = (v != m_valid) || (b != m_blank) || (e != m_error) || (nh != m_hex);
            m_valid = v; m_blank = b; m_error = e; m_hex = nh;
        end
    endtask

    // One clock with pattern p (active-high) on the bus, checked against the model.
    task automatic cyc(input logic [6:0] p);
        i_seg = ALOW ? ~p : p;
        @(posedge clk);
        #1;
        model_step(p);
        chk("cyc_hex",    32'(o_hex),    32'(m_hex));
        chk("cyc_valid",  32'(o_valid),  32'(m_valid));
        chk("cyc_blank",  32'(o_blank),  32'(m_blank));
        chk("cyc_error",  32'(o_error),  32'(m_error));
        chk("cyc_update", 32'(o_update), 32'(m_update));
        if (o_update) upd_cnt++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hex"},    32'(o_hex),    32'h0);
        chk({tag, "_valid"},  32'(o_valid),  32'h0);
        chk({tag, "_blank"},  32'(o_blank),  32'h0);
        chk({tag, "_error"},  32'(o_error),  32'h0);
        chk({tag, "_update"}, 32'(o_update), 32'h0);
    endtask

    initial begin
        logic [6:0] pat;
        int         hold;

        for (int i = 0; i < 16; i++) tab[i] = '{glyphs[i], 1'b1, 1'b0, 1'b0, 4'(i)};
        tab[16] = '{7'h00, 1'b0, 1'b1, 1'b0, 4'hF};
        tab[17] = '{7'h49, 1'b0, 1'b0, 1'b1, 4'hF};
`ifdef SEG7_READER_ALT_GLYPH_EN
        tab[18] = '{7'h27, 1'b1, 1'b0, 1'b0, 4'h7};
        tab[19] = '{7'h67, 1'b1, 1'b0, 1'b0, 4'h9};
        tab[20] = '{7'h00, 1'b0, 1'b1, 1'b0, 4'h9};
`else
        tab[18] = '{7'h27, 1'b0, 1'b0, 1'b1, 4'hF};
        tab[19] = '{7'h67, 1'b0, 1'b0, 1'b1, 4'hF};
        tab[20] = '{7'h00, 1'b0, 1'b1, 1'b0, 4'hF};
`endif
        tab[21] = '{7'h08, 1'b0, 1'b0, 1'b1, 4'hF};

        // Reset with all segments off
        n_rst = 1'b0;
        i_seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        n_rst = 1'b1;
        model_reset();
        upd_cnt = 0;
        repeat (10) cyc(7'h00);
        chk("rst_blank_upd", 32'(upd_cnt), 32'd1);
        chk("rst_blank",     32'(o_blank), 32'd1);
        chk("rst_blank_val", 32'(o_valid), 32'd0);
        chk("rst_blank_err", 32'(o_error), 32'd0);
        chk("rst_blank_hex", 32'(o_hex),   32'd0);

        for (int i = 0; i < 22; i++) begin
            repeat (12) cyc(tab[i].pat);
            chk("tab_valid", 32'(o_valid), 32'(tab[i].valid));
            chk("tab_blank", 32'(o_blank), 32'(tab[i].blank));
            chk("tab_error", 32'(o_error), 32'(tab[i].error));
            chk("tab_hex",   32'(o_hex),   32'(tab[i].hex));
        end

        // Digit 2: commit lands exactly on the 7th edge
        upd_cnt = 0;
        repeat (6) cyc(7'h5B);
        chk("d2_early_upd", 32'(upd_cnt), 32'd0);
        cyc(7'h5B);
        chk("d2_upd",   32'(o_update), 32'd1);
        chk("d2_hex",   32'(o_hex),    32'd2);
        chk("d2_valid", 32'(o_valid),  32'd1);
        upd_cnt = 0;
        repeat (20) cyc(7'h5B);
        chk("d2_quiet", 32'(upd_cnt), 32'd0);

        // Short glitch to '1' and back: recommit without an update pulse
        upd_cnt = 0;
        repeat (3) cyc(7'h06);
        repeat (15) cyc(7'h5B);
        chk("glitch_upd", 32'(upd_cnt), 32'd0);
        chk("glitch_hex", 32'(o_hex),   32'd2);

        upd_cnt = 0;
        repeat (10) cyc(7'h49);
        chk("err_upd",   32'(upd_cnt), 32'd1);
        chk("err_error", 32'(o_error), 32'd1);
        chk("err_valid", 32'(o_valid), 32'd0);
        chk("err_hex",   32'(o_hex),   32'd2);

        repeat (10) cyc(7'h67);
`ifdef SEG7_READER_ALT_GLYPH_EN
        chk("alt9_hex",   32'(o_hex),   32'd9);
        chk("alt9_valid", 32'(o_valid), 32'd1);
`else
        chk("alt9_error", 32'(o_error), 32'd1);
        chk("alt9_hex",   32'(o_hex),   32'd2);
`endif

        // Reset two cycles into counting digit 3
        repeat (10) cyc(7'h6D);
        repeat (5) cyc(7'h4F);
        #2;
        n_rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
        upd_cnt = 0;
        repeat (6) cyc(7'h4F);
        chk("midrst_early", 32'(upd_cnt), 32'd0);
        cyc(7'h4F);
        chk("midrst_upd",   32'(o_update), 32'd1);
        chk("midrst_hex",   32'(o_hex),    32'd3);
        chk("midrst_valid", 32'(o_valid),  32'd1);

        // Random bus traffic: glyphs, blanks, alternates, garbage and glitches
        pat = 7'h00;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: pat = glyphs[$urandom_range(0, 15)];
                6:                pat = 7'h00;
                7:                pat = ($urandom_range(0, 1) == 0) ? 7'h27 : 7'h67;
                8:                pat = 7'($urandom_range(0, 127));
                default:          pat = pat;
            endcase
            hold = $urandom_range(1, 9);
            repeat (hold) cyc(pat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
